// File: rtl/addsum_pkg.sv
// Shared definitions for the accumulate-in-RAM buffer: controller state encoding
// and the latency constants that the accumulator and its controller must agree on.
package addsum_pkg;

    // Beat-to-write latency of the accumulator; also the controller's drain length.
    localparam int C_WDLY = 7;

    // Read-address-to-data latency of the accumulator RAM.
    localparam int C_RLAT = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACC   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_GAP   = 3'd3,
        ST_READ  = 3'd4,
        ST_RWAIT = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

endpackage

// File: rtl/addsum_ctrl_dly.sv
// Fixed-depth shift delay: O_q is I_d delayed by exactly DEPTH clock cycles,
// cleared asynchronously by reset.
module dly #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 3
) (
    input  logic             I_clk,
    input  logic             I_rst_n,
    input  logic [WIDTH-1:0] I_d,
    output logic [WIDTH-1:0] O_q
);

    logic [WIDTH-1:0] r_sr [DEPTH];

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_sr[i] <= '0;
            end
        end else begin
            r_sr[0] <= I_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    assign O_q = r_sr[DEPTH-1];

endmodule

// File: rtl/addsum_ctrl.sv
// Sequencing controller for the accumulate-in-RAM buffer: runs npass accumulation
// passes of len beats each, drains writes between passes, then streams the row out.
module addsum_ctrl
    import addsum_pkg::*;
#(
    parameter int C_ASIZE = 10,
    parameter int C_PSIZE = 8,
    parameter int C_WDLY  = addsum_pkg::C_WDLY,
    parameter int C_RLAT  = addsum_pkg::C_RLAT
) (
    input  logic               I_clk,
    input  logic               I_rst_n,
    input  logic               I_start,
    input  logic [C_PSIZE-1:0] I_npass,
    input  logic [C_ASIZE:0]   I_len,
    input  logic               I_src_valid,
    input  logic               I_dst_ready,
    output logic               O_src_ready,
    output logic               O_first_flag,
    output logic               O_dven,
    output logic               O_dv_pre4,
    output logic [C_ASIZE-1:0] O_raddr,
    output logic               O_rd_valid,
    output logic               O_busy,
    output logic               O_done
);

    localparam int C_CMAX = (C_WDLY > C_RLAT) ? C_WDLY : C_RLAT;
    localparam int C_CNTW = $clog2(C_CMAX + 1);

    state_t             r_state;
    logic [C_ASIZE-1:0] r_lenm1;
    logic [C_PSIZE-1:0] r_npassm1;
    logic [C_ASIZE-1:0] r_pos;
    logic [C_PSIZE-1:0] r_pass;
    logic [C_CNTW-1:0]  r_cnt;
    logic               r_src_ready;
    logic               r_first_flag;
    logic               r_dven;
    logic [C_ASIZE-1:0] r_raddr;
    logic               r_busy;
    logic               r_done;

    logic               w_beat;
    logic               w_issue;

    // r_src_ready is only ever set in ACC, so beats outside ACC cannot occur.
    assign w_beat  = I_src_valid & r_src_ready;
    assign w_issue = (r_state == ST_READ) & I_dst_ready;

    // Lengths and pass counts are stored minus one so that a full 2^C_ASIZE row
    // fits the position counter and the last-position compare stays narrow.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_state      <= ST_IDLE;
            r_lenm1      <= '0;
            r_npassm1    <= '0;
            r_pos        <= '0;
            r_pass       <= '0;
            r_cnt        <= '0;
            r_src_ready  <= 1'b0;
            r_first_flag <= 1'b0;
            r_dven       <= 1'b0;
            r_raddr      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (I_start) begin
                        r_lenm1   <= C_ASIZE'(I_len - 1'b1);
                        r_npassm1 <= I_npass - 1'b1;
                        r_pos     <= '0;
                        r_pass    <= '0;
                        r_busy    <= 1'b1;
                        if ((I_npass == '0) || (I_len == '0)) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state      <= ST_ACC;
                            r_src_ready  <= 1'b1;
                            r_dven       <= 1'b1;
                            r_first_flag <= 1'b1;
                        end
                    end
                end

                ST_ACC: begin
                    if (w_beat) begin
                        if (r_pos == r_lenm1) begin
                            r_pos       <= '0;
                            r_src_ready <= 1'b0;
                            r_cnt       <= C_CNTW'(C_WDLY - 1);
                            r_state     <= ST_DRAIN;
                        end else begin
                            r_pos <= r_pos + 1'b1;
                        end
                    end
                end

                // Enable stays high so the accumulator pipeline can finish its writes.
                ST_DRAIN: begin
                    if (r_cnt == '0) begin
                        r_dven <= 1'b0;
                        if (r_pass == r_npassm1) begin
                            r_first_flag <= 1'b0;
                            r_raddr      <= '0;
                            r_state      <= ST_READ;
                        end else begin
                            r_pass  <= r_pass + 1'b1;
                            r_state <= ST_GAP;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                ST_GAP: begin
                    r_first_flag <= 1'b0;
                    r_dven       <= 1'b1;
                    r_src_ready  <= 1'b1;
                    r_state      <= ST_ACC;
                end

                ST_READ: begin
                    if (w_issue) begin
                        if (r_pos == r_lenm1) begin
                            r_cnt   <= C_CNTW'(C_RLAT - 1);
                            r_state <= ST_RWAIT;
                        end else begin
                            r_pos   <= r_pos + 1'b1;
                            r_raddr <= r_pos + 1'b1;
                        end
                    end
                end

                ST_RWAIT: begin
                    if (r_cnt == '0) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_raddr <= '0;
                    r_pos   <= '0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Read data valid tracks the issue strobe through the RAM's read latency.
    dly #(
        .WIDTH (1),
        .DEPTH (C_RLAT)
    ) u_rd_dly (
        .I_clk   (I_clk),
        .I_rst_n (I_rst_n),
        .I_d     (w_issue),
        .O_q     (O_rd_valid)
    );

    assign O_src_ready  = r_src_ready;
    assign O_first_flag = r_first_flag;
    assign O_dven       = r_dven;
    assign O_dv_pre4    = w_beat;
    assign O_raddr      = r_raddr;
    assign O_busy       = r_busy;
    assign O_done       = r_done;

endmodule

// File: doc/addsum_ctrl.md
# addsum_ctrl

Sequencing controller for the accumulate-in-RAM buffer: it runs a configurable number of accumulation passes over a row of partial sums, then streams the finished sums out. It sits between the upstream partial-sum producer and the accumulator RAM block, and drives that block's first-pass, enable, beat-valid and read-address inputs. It guarantees each pass's writes have landed before the next pass re-reads them.

## Interface
- C_ASIZE, 10, accumulator address width; row length up to 2^C_ASIZE
- C_PSIZE, 8, pass-count width
- C_WDLY, 7, accumulator beat-to-write latency (drain length)
- C_RLAT, 3, accumulator read-address-to-data latency
- I_clk  in  1  single clock
- I_rst_n  in  1  asynchronous active-low reset
- I_start  in  1  start pulse; sampled only in IDLE
- I_npass  in  C_PSIZE  passes per job; latched at start
- I_len  in  C_ASIZE+1  positions per pass; latched at start
- I_src_valid  in  1  upstream beat valid
- O_src_ready  out  1  upstream ready, registered
- O_first_flag  out  1  to accumulator: zero the old sum (pass 0)
- O_dven  out  1  to accumulator: accumulate-window enable
- O_dv_pre4  out  1  to accumulator: beat strobe = I_src_valid & O_src_ready
- O_raddr  out  C_ASIZE  to accumulator: readout address
- O_rd_valid  out  1  accumulator read data valid this cycle
- O_busy  out  1  high whenever the state is not IDLE
- O_done  out  1  one-cycle job-complete pulse

## Operation
- States: IDLE, ACC, DRAIN, GAP, READ, RWAIT, DONE.
- IDLE: all outputs 0. I_start=1 latches npass and len, clears pos and pass, then enters ACC. If npass=0 or len=0, it enters DONE instead.
- ACC: O_dven=1, O_src_ready=1. Each beat increments pos. On the beat with pos=len-1, pos clears and the state goes to DRAIN.
- DRAIN: O_dven=1, O_src_ready=0, lasts C_WDLY cycles.
  - If pass=npass-1, go to READ.
  - Otherwise, increment pass and go to GAP.
- GAP: one cycle with O_dven=0, which resets the accumulator's address counters. O_first_flag updates here, then the state goes to ACC.
- O_first_flag is 1 from leaving IDLE until the end of pass 0's GAP. It is therefore stable through pass 0's drain.
- READ: O_dven=0.
  - Issue O_raddr=pos on each cycle with I_dst_ready=1, then increment pos.
  - After the issue at pos=len-1, go to RWAIT.
- RWAIT: lasts C_RLAT cycles, then goes to DONE.
- DONE: O_done=1 for one cycle, then the state returns to IDLE.
- I_start outside IDLE is ignored.
- I_src_valid outside ACC is ignored.
- O_dv_pre4 is never high outside ACC.
- Reset asserted mid-job: state goes to IDLE and all outputs go to 0 asynchronously. The accumulated data is discarded.

## Timing
- Every output except O_dv_pre4 is registered. O_dv_pre4 is combinational from I_src_valid.
- Reset values: O_src_ready, O_first_flag, O_dven, O_dv_pre4, O_rd_valid, O_busy and O_done are all 0; O_raddr is 0.
- O_rd_valid equals the read-issue strobe delayed exactly C_RLAT cycles.
- Cost per non-final pass with an always-valid source: len + C_WDLY + 1 cycles. The final pass has no GAP.
- No read-after-write hazard: a pass's last write lands within C_WDLY cycles of its last beat, before the next pass's first read.
- An I_start arriving in the same cycle that DONE returns to IDLE is ignored. A start is accepted only when already in IDLE.

## Structure
- Shared package addsum_pkg holds the state encoding and the default latency constants C_WDLY=7 and C_RLAT=3. The accumulator and this controller both use these constants.
- One sub-module: the existing `dly` shift-delay (width 1, depth C_RLAT), which generates O_rd_valid from the issue strobe.
- The FSM, the pos/pass counters and the drain/wait counter live in this block.

## Test plan
- npass=2, len=4, src_valid and dst_ready held 1, start at cycle 0:
  - ACC 1-4, DRAIN 5-11, GAP 12, ACC 13-16, DRAIN 17-23, READ 24-27.
  - O_raddr 0..3; O_rd_valid at 27-30; O_done at 31.
  - O_first_flag=1 only during cycles 1-12.
- Source backpressure: npass=1, len=4, src_valid toggling 1,0,1,0 -> exactly 4 O_dv_pre4 pulses; DRAIN begins after the 4th pulse.
- dst_ready low for 2 cycles mid-READ -> O_raddr holds, with no skipped or duplicated address; O_rd_valid shows the same gap C_RLAT cycles later.
- npass=0 or len=0 -> O_done one cycle after start; O_dven never rises.
- Reset pulsed during DRAIN -> all outputs 0 immediately. A new start then runs a full job from pass 0 with first_flag=1.
- len=1024 with C_ASIZE=10 -> pos wraps correctly; the last O_raddr is 1023 and O_done follows.
